// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed 32-bit restoring divider (quotient to LO, remainder to HI)
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] div_lo_out,
    output logic [31:0] div_hi_out,
    output logic        div_done,
    output logic        div_zero,
    output logic        div_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] dvs_mag;
    logic [4:0]  cnt;
    logic        sign_q;
    logic        sign_r;

    logic        accept;
    logic        accept_zero;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;

    // Start decode, operand magnitudes and one restoring trial subtraction.
    always_comb begin
        accept       = (state == S_IDLE) && div_start && (divisor != 32'd0);
        accept_zero  = (state == S_IDLE) && div_start && (divisor == 32'd0);
        // Two's complement negation keeps 0x80000000 as its own magnitude,
        // which is exactly right when read back as unsigned.
        dividend_mag = dividend[31] ? (32'd0 - dividend) : dividend;
        divisor_mag  = divisor[31]  ? (32'd0 - divisor)  : divisor;
        // 33 bits: the shifted remainder can exceed 32 bits before the subtract.
        trial        = {rem, quot[31]};
        diff         = trial - {1'b0, dvs_mag};
        // The partial remainder is always below the divisor, so the trial is
        // below twice the divisor and bit 32 of the difference is a clean borrow.
        fits         = ~diff[32];
    end

    // Control state, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rem        <= 32'd0;
            quot       <= 32'd0;
            dvs_mag    <= 32'd0;
            cnt        <= 5'd0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div_lo_out <= 32'd0;
            div_hi_out <= 32'd0;
            div_done   <= 1'b0;
            div_zero   <= 1'b0;
            div_busy   <= 1'b0;
        end else begin
            div_done <= 1'b0;
            div_zero <= accept_zero;
            // Busy covers the accepting cycle through the FIX cycle's output,
            // i.e. it falls one cycle after the state returns to IDLE.
            div_busy <= (state != S_IDLE) || accept;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        quot    <= dividend_mag;
                        dvs_mag <= divisor_mag;
                        rem     <= 32'd0;
                        cnt     <= 5'd0;
                        sign_q  <= dividend[31] ^ divisor[31];
                        sign_r  <= dividend[31];
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fits) begin
                        rem  <= diff[31:0];
                        quot <= {quot[30:0], 1'b1};
                    end else begin
                        rem  <= trial[31:0];
                        quot <= {quot[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    div_lo_out <= sign_q ? (32'd0 - quot) : quot;
                    div_hi_out <= sign_r ? (32'd0 - rem)  : rem;
                    div_done   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_lo_out;
    logic [31:0] div_hi_out;
    logic        div_done;
    logic        div_zero;
    logic        div_busy;

    int vectors;
    int miscompares;
    logic [31:0] prev_lo;
    logic [31:0] prev_hi;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .div_start  (div_start),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_lo_out (div_lo_out),
        .div_hi_out (div_hi_out),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation. Start is driven at a negedge and accepted at the next
    // posedge (E0); sample k is taken at the negedge following edge Ek.
    // inj_at >= 0: pulse a second start with other operands at sample inj_at.
    // rst_at >= 0: assert reset at sample rst_at, expect an abort.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input int inj_at, input int rst_at, input bit chk_busy);
        int done_at;
        int ndone;
        int busy_cnt;
        int zero_cnt;
        logic [31:0] lo_at_done;
        logic [31:0] hi_at_done;
        done_at = -1;
        ndone = 0;
        busy_cnt = 0;
        zero_cnt = 0;
        lo_at_done = 32'd0;
        hi_at_done = 32'd0;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        dividend  = 32'h1234_5678;
        divisor   = 32'h0000_0003;
        for (int k = 0; k < 45; k++) begin
            if (div_busy) busy_cnt++;
            if (div_zero) zero_cnt++;
            if (div_done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    lo_at_done = div_lo_out;
                    hi_at_done = div_hi_out;
                end
            end
            if (k == 20 && rst_at < 0) begin
                chk({tag, " lo_held_in_run"}, div_lo_out, prev_lo);
                chk({tag, " hi_held_in_run"}, div_hi_out, prev_hi);
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk({tag, " rst_lo"}, div_lo_out, 32'd0);
                chk({tag, " rst_hi"}, div_hi_out, 32'd0);
                chk({tag, " rst_busy"}, {31'd0, div_busy}, 32'd0);
                chk({tag, " rst_done"}, {31'd0, div_done}, 32'd0);
                chk({tag, " rst_zero"}, {31'd0, div_zero}, 32'd0);
                reset = 1'b0;
            end
            div_start = 1'b0;
            if (k == inj_at) begin
                div_start = 1'b1;
                dividend  = 32'd50;
                divisor   = 32'd3;
            end
            if (k == rst_at) reset = 1'b1;
            @(negedge clk);
        end
        div_start = 1'b0;
        if (rst_at >= 0) begin
            chk({tag, " abort_no_done"}, ndone, 32'd0);
            prev_lo = 32'd0;
            prev_hi = 32'd0;
        end else begin
            chk({tag, " done_latency"}, done_at, 32'd33);
            chk({tag, " done_count"}, ndone, 32'd1);
            chk({tag, " lo"}, lo_at_done, elo);
            chk({tag, " hi"}, hi_at_done, ehi);
            chk({tag, " lo_hold"}, div_lo_out, elo);
            chk({tag, " no_zero"}, zero_cnt, 32'd0);
            if (chk_busy) chk({tag, " busy_cycles"}, busy_cnt, 32'd34);
            prev_lo = elo;
            prev_hi = ehi;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_lo     = 32'd0;
        prev_hi     = 32'd0;
        reset       = 1'b1;
        div_start   = 1'b0;
        dividend    = 32'd0;
        divisor     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset lo", div_lo_out, 32'd0);
        chk("reset hi", div_hi_out, 32'd0);
        chk("reset done", {31'd0, div_done}, 32'd0);
        chk("reset zero", {31'd0, div_zero}, 32'd0);
        chk("reset busy", {31'd0, div_busy}, 32'd0);
        reset = 1'b0;

        run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1, -1, -1, 1'b1);

        // Divide by zero with prior results 3/1 in place.
        @(negedge clk);
        dividend  = 32'd99;
        divisor   = 32'd0;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        chk("dz zero_pulse", {31'd0, div_zero}, 32'd1);
        chk("dz busy", {31'd0, div_busy}, 32'd0);
        chk("dz done", {31'd0, div_done}, 32'd0);
        begin
            int zdone;
            zdone = 0;
            @(negedge clk);
            chk("dz zero_once", {31'd0, div_zero}, 32'd0);
            for (int k = 0; k < 40; k++) begin
                if (div_done) zdone++;
                @(negedge clk);
            end
            chk("dz never_done", zdone, 32'd0);
        end
        chk("dz lo_kept", div_lo_out, 32'd3);
        chk("dz hi_kept", div_hi_out, 32'd1);

        run_div("-7/2",  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, -1, 1'b0);
        run_div("7/-2",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, -1, -1, 1'b0);
        run_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, -1, -1, 1'b0);
        run_div("0/5",   32'd0,         32'd5,         32'd0,         32'd0,         -1, -1, 1'b0);
        run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       -1, -1, 1'b0);
        run_div("max/1", 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         -1, -1, 1'b0);
        run_div("5/7",   32'd5,         32'd7,         32'd0,         32'd5,         -1, -1, 1'b0);
        run_div("100/7 busy_start", 32'd100, 32'd7,    32'd14,        32'd2,         10, -1, 1'b1);
        run_div("abort", 32'd1000,      32'd3,         32'd0,         32'd0,         -1, 15, 1'b0);
        run_div("9/4",   32'd9,         32'd4,         32'd2,         32'd1,         -1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
